// File: rtl/vending_change_controller_if.sv
// Coin/selection inputs and dispenser/change outputs of the vending change controller.
// Prices and coin values travel with the bus because they size the same datapath.
interface vending_change_controller_if #(
  parameter int NUM_ITEMS  = 4,
  parameter int NUM_COINS  = 3,
  parameter int TOTAL_BITS = 31
);
  logic [NUM_COINS-1:0]            i_input_coin;
  logic [NUM_ITEMS-1:0]            i_select_item;
  logic                            i_trigger_return;
  logic                            i_restock;
  logic [NUM_ITEMS*TOTAL_BITS-1:0] item_price;
  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value;
  logic [NUM_ITEMS-1:0]            o_available_item;
  logic [NUM_ITEMS-1:0]            o_output_item;
  logic [NUM_COINS-1:0]            o_return_coin;
  logic [TOTAL_BITS-1:0]           o_balance;
  logic                            o_busy;
  logic                            o_coin_reject;

  modport master (
    output i_input_coin, i_select_item, i_trigger_return, i_restock, item_price, coin_value,
    input  o_available_item, o_output_item, o_return_coin, o_balance, o_busy, o_coin_reject
  );

  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return, i_restock, item_price, coin_value,
    output o_available_item, o_output_item, o_return_coin, o_balance, o_busy, o_coin_reject
  );
endinterface

// File: rtl/vending_change_controller.sv
// Vending balance, per-item stock, inactivity timer and greedy one-coin-per-cycle change return.
// Coin values are expected strictly descending with index so the lowest fitting index is the largest coin.
module vending_change_controller #(
  parameter int NUM_ITEMS  = 4,
  parameter int NUM_COINS  = 3,
  parameter int TOTAL_BITS = 31,
  parameter int STOCK_BITS = 4,
  parameter int INIT_STOCK = 3,
  parameter int TIMEOUT    = 100
) (
  input logic                       clk,
  input logic                       reset,
  vending_change_controller_if.slave bus
);
  localparam int SUM_W   = TOTAL_BITS + NUM_COINS;
  localparam int WIDE_W  = SUM_W + 1;
  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]    TIMER_LOAD = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0]    TIMER_ONE  = TIMER_W'(1);
  localparam logic [STOCK_BITS-1:0] STOCK_FULL = {STOCK_BITS{1'b1}};
  localparam logic [STOCK_BITS-1:0] STOCK_INIT = STOCK_BITS'(INIT_STOCK);
  localparam logic [STOCK_BITS-1:0] STOCK_ONE  = STOCK_BITS'(1);
  localparam logic [WIDE_W-1:0]     BAL_MAX    = {{(WIDE_W-TOTAL_BITS){1'b0}}, {TOTAL_BITS{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RETURN = 2'd2} state_t;

  state_t                  state_r, state_nxt_s;
  logic [TOTAL_BITS-1:0]   balance_r, balance_nxt_s, purchase_bal_s;
  logic [TIMER_W-1:0]      timer_r, timer_nxt_s;
  logic [STOCK_BITS-1:0]   stock_r [NUM_ITEMS];
  logic [NUM_ITEMS-1:0]    output_item_r, serve_s, avail_s;
  logic                    coin_reject_r, accept_s, reject_s, activity_s, expire_s;
  logic                    served_any_s, coin_found_s;
  logic [SUM_W-1:0]        coin_sum_s;
  logic [WIDE_W-1:0]       wide_total_s;
  logic [TOTAL_BITS-1:0]   price_taken_s, return_value_s;
  logic [NUM_COINS-1:0]    return_coin_s;

  // Availability and lowest-index serve arbitration
  always_comb begin
    avail_s       = {NUM_ITEMS{1'b0}};
    serve_s       = {NUM_ITEMS{1'b0}};
    price_taken_s = {TOTAL_BITS{1'b0}};
    served_any_s  = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_s[i] = (state_r != RETURN) &&
                   (bus.item_price[i*TOTAL_BITS +: TOTAL_BITS] <= balance_r) &&
                   (stock_r[i] != {STOCK_BITS{1'b0}});
      if (bus.i_select_item[i] && avail_s[i] && !served_any_s) begin
        serve_s[i]    = 1'b1;
        price_taken_s = bus.item_price[i*TOTAL_BITS +: TOTAL_BITS];
        served_any_s  = 1'b1;
      end else begin
        serve_s[i]    = 1'b0;
      end
    end
  end

  // Coin sum, overflow-guarded acceptance and greedy change coin selection
  always_comb begin
    coin_sum_s     = {SUM_W{1'b0}};
    return_coin_s  = {NUM_COINS{1'b0}};
    return_value_s = {TOTAL_BITS{1'b0}};
    coin_found_s   = 1'b0;
    for (int j = 0; j < NUM_COINS; j++) begin
      if (bus.i_input_coin[j]) begin
        coin_sum_s = coin_sum_s + SUM_W'(bus.coin_value[j*TOTAL_BITS +: TOTAL_BITS]);
      end else begin
        coin_sum_s = coin_sum_s;
      end
      if ((state_r == RETURN) && !coin_found_s && (balance_r != {TOTAL_BITS{1'b0}}) &&
          (bus.coin_value[j*TOTAL_BITS +: TOTAL_BITS] <= balance_r)) begin
        return_coin_s[j] = 1'b1;
        return_value_s   = bus.coin_value[j*TOTAL_BITS +: TOTAL_BITS];
        coin_found_s     = 1'b1;
      end else begin
        return_coin_s[j] = 1'b0;
      end
    end
    // price_taken never exceeds balance, so the wide subtraction cannot wrap
    wide_total_s = WIDE_W'(balance_r) + WIDE_W'(coin_sum_s) - WIDE_W'(price_taken_s);
    accept_s     = (|bus.i_input_coin) && (state_r != RETURN) && (wide_total_s <= BAL_MAX);
    reject_s     = (|bus.i_input_coin) && !accept_s;
    activity_s   = accept_s || served_any_s;
    if (accept_s) begin
      purchase_bal_s = wide_total_s[TOTAL_BITS-1:0];
    end else begin
      purchase_bal_s = balance_r - price_taken_s;
    end
  end

  // Next state, balance and inactivity timer
  always_comb begin
    state_nxt_s   = state_r;
    balance_nxt_s = balance_r;
    timer_nxt_s   = timer_r;
    expire_s      = !activity_s && (timer_r <= TIMER_ONE);
    case (state_r)
      IDLE: begin
        balance_nxt_s = purchase_bal_s;
        if (purchase_bal_s != {TOTAL_BITS{1'b0}}) begin
          state_nxt_s = ACTIVE;
          timer_nxt_s = TIMER_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        balance_nxt_s = purchase_bal_s;
        if ((bus.i_trigger_return || expire_s) && (purchase_bal_s != {TOTAL_BITS{1'b0}})) begin
          state_nxt_s = RETURN;
        end else if (purchase_bal_s == {TOTAL_BITS{1'b0}}) begin
          state_nxt_s = IDLE;
        end else if (activity_s) begin
          timer_nxt_s = TIMER_LOAD;
        end else begin
          timer_nxt_s = timer_r - TIMER_ONE;
        end
      end
      RETURN: begin
        // With no fitting coin the sub-coin residue is forfeited
        if (coin_found_s) begin
          balance_nxt_s = balance_r - return_value_s;
        end else begin
          balance_nxt_s = {TOTAL_BITS{1'b0}};
        end
        if (balance_nxt_s == {TOTAL_BITS{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RETURN;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        balance_nxt_s = {TOTAL_BITS{1'b0}};
        timer_nxt_s   = {TIMER_W{1'b0}};
      end
    endcase
  end

  // State, balance, timer, stock and registered pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      balance_r     <= {TOTAL_BITS{1'b0}};
      timer_r       <= {TIMER_W{1'b0}};
      output_item_r <= {NUM_ITEMS{1'b0}};
      coin_reject_r <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_r[i] <= STOCK_INIT;
    end else begin
      state_r       <= state_nxt_s;
      balance_r     <= balance_nxt_s;
      timer_r       <= timer_nxt_s;
      output_item_r <= serve_s;
      coin_reject_r <= reject_s;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (bus.i_restock) begin
          stock_r[i] <= STOCK_FULL;
        end else if (serve_s[i]) begin
          stock_r[i] <= stock_r[i] - STOCK_ONE;
        end else begin
          stock_r[i] <= stock_r[i];
        end
      end
    end
  end

  assign bus.o_available_item = avail_s;
  assign bus.o_output_item    = output_item_r;
  assign bus.o_return_coin    = return_coin_s;
  assign bus.o_balance        = balance_r;
  assign bus.o_busy           = (state_r == RETURN);
  assign bus.o_coin_reject    = coin_reject_r;
endmodule

// File: tb/tb_vending_change_controller.sv
// Bench for vending_change_controller: two instances (INIT_STOCK 3 and 1) share directed stimulus and
// are checked every cycle against a rule-level model, plus hand-computed literal expectations.
module tb_vending_change_controller;
  localparam int NI = 4;
  localparam int NC = 3;
  localparam int TW = 11;
  localparam int TO = 8;
  localparam int MAXBAL = 2047;

  int price_tab [NI] = '{400, 500, 1000, 2000};
  int coin_tab  [NC] = '{1000, 500, 100};
  int init_tab  [2]  = '{3, 1};

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0] coin;
  logic [NI-1:0] sel;
  logic trig, restock;

  always #5 clk = ~clk;

  vending_change_controller_if #(.NUM_ITEMS(NI), .NUM_COINS(NC), .TOTAL_BITS(TW)) if_a ();
  vending_change_controller_if #(.NUM_ITEMS(NI), .NUM_COINS(NC), .TOTAL_BITS(TW)) if_b ();

  assign if_a.i_input_coin = coin;    assign if_b.i_input_coin = coin;
  assign if_a.i_select_item = sel;    assign if_b.i_select_item = sel;
  assign if_a.i_trigger_return = trig; assign if_b.i_trigger_return = trig;
  assign if_a.i_restock = restock;    assign if_b.i_restock = restock;
  assign if_a.item_price = {11'd2000, 11'd1000, 11'd500, 11'd400};
  assign if_b.item_price = {11'd2000, 11'd1000, 11'd500, 11'd400};
  assign if_a.coin_value = {11'd100, 11'd500, 11'd1000};
  assign if_b.coin_value = {11'd100, 11'd500, 11'd1000};

  vending_change_controller #(.NUM_ITEMS(NI), .NUM_COINS(NC), .TOTAL_BITS(TW), .STOCK_BITS(4),
                              .INIT_STOCK(3), .TIMEOUT(TO))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  vending_change_controller #(.NUM_ITEMS(NI), .NUM_COINS(NC), .TOTAL_BITS(TW), .STOCK_BITS(4),
                              .INIT_STOCK(1), .TIMEOUT(TO))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));

  logic [TW-1:0] d_bal   [2];
  logic [NI-1:0] d_avail [2];
  logic [NI-1:0] d_item  [2];
  logic [NC-1:0] d_ret   [2];
  logic          d_busy  [2];
  logic          d_rej   [2];
  assign d_bal[0] = if_a.o_balance;          assign d_bal[1] = if_b.o_balance;
  assign d_avail[0] = if_a.o_available_item; assign d_avail[1] = if_b.o_available_item;
  assign d_item[0] = if_a.o_output_item;     assign d_item[1] = if_b.o_output_item;
  assign d_ret[0] = if_a.o_return_coin;      assign d_ret[1] = if_b.o_return_coin;
  assign d_busy[0] = if_a.o_busy;            assign d_busy[1] = if_b.o_busy;
  assign d_rej[0] = if_a.o_coin_reject;      assign d_rej[1] = if_b.o_coin_reject;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0d want=%0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 active, 2 paying change
  int  m_bal [2], m_mode [2], m_timer [2], m_item [2], m_rej [2];
  int  m_stock [2][NI];
  bit  m_valid = 1'b0;

  task automatic model_step(input int k);
    int sum, srv, pt, nb, v;
    bit any, acc, act;
    if (reset) begin
      m_bal[k] = 0; m_mode[k] = 0; m_timer[k] = 0; m_item[k] = 0; m_rej[k] = 0;
      for (int i = 0; i < NI; i++) m_stock[k][i] = init_tab[k];
      return;
    end
    sum = 0;
    for (int j = 0; j < NC; j++) if (coin[j]) sum += coin_tab[j];
    srv = -1;
    if (m_mode[k] != 2)
      for (int i = 0; i < NI; i++)
        if (srv < 0 && sel[i] && price_tab[i] <= m_bal[k] && m_stock[k][i] > 0) srv = i;
    pt  = (srv >= 0) ? price_tab[srv] : 0;
    any = (coin != '0);
    acc = any && (m_mode[k] != 2) && (m_bal[k] + sum - pt <= MAXBAL);
    m_rej[k]  = (any && !acc) ? 1 : 0;
    m_item[k] = (srv >= 0) ? (1 << srv) : 0;
    if (restock) for (int i = 0; i < NI; i++) m_stock[k][i] = 15;
    else if (srv >= 0) m_stock[k][srv]--;
    if (m_mode[k] == 2) begin
      v = 0;
      for (int j = NC - 1; j >= 0; j--) if (coin_tab[j] <= m_bal[k]) v = coin_tab[j];
      m_bal[k] = (v > 0) ? m_bal[k] - v : 0;
      if (m_bal[k] == 0) m_mode[k] = 0;
    end else begin
      nb  = m_bal[k] + (acc ? sum : 0) - pt;
      act = acc || (srv >= 0);
      if (m_mode[k] == 0) begin
        if (nb > 0) begin m_mode[k] = 1; m_timer[k] = TO; end
      end else if ((trig || (!act && m_timer[k] <= 1)) && nb > 0) m_mode[k] = 2;
      else if (nb == 0) m_mode[k] = 0;
      else if (act) m_timer[k] = TO;
      else m_timer[k]--;
      m_bal[k] = nb;
    end
  endtask

  function automatic int exp_ret(input int k);
    int r;
    r = 0;
    if (m_mode[k] == 2 && m_bal[k] > 0)
      for (int j = NC - 1; j >= 0; j--) if (coin_tab[j] <= m_bal[k]) r = 1 << j;
    return r;
  endfunction

  function automatic int exp_avail(input int k);
    int r;
    r = 0;
    for (int i = 0; i < NI; i++)
      if (m_mode[k] != 2 && price_tab[i] <= m_bal[k] && m_stock[k][i] > 0) r |= (1 << i);
    return r;
  endfunction

  // Compare both instances against the model, then advance the model with the inputs the next edge samples
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        check("balance", k, 32'(d_bal[k]), m_bal[k]);
        check("busy", k, 32'(d_busy[k]), (m_mode[k] == 2) ? 1 : 0);
        check("output_item", k, 32'(d_item[k]), m_item[k]);
        check("coin_reject", k, 32'(d_rej[k]), m_rej[k]);
        check("return_coin", k, 32'(d_ret[k]), exp_ret(k));
        check("available", k, 32'(d_avail[k]), exp_avail(k));
      end
    end
    for (int k = 0; k < 2; k++) model_step(k);
    if (reset) m_valid = 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [NC-1:0] c, input logic [NI-1:0] s, input logic t, input logic r);
    coin = c; sel = s; trig = t; restock = r;
    @(posedge clk); #1;
    coin = '0; sel = '0; trig = 1'b0; restock = 1'b0;
  endtask

  initial begin
    reset = 1'b1; coin = '0; sel = '0; trig = 1'b0; restock = 1'b0;
    // reset state
    idle(2);
    check("rst_balance", 0, 32'(if_a.o_balance), 0);
    check("rst_outputs", 0, {19'd0, if_a.o_output_item, if_a.o_return_coin, if_a.o_available_item,
                             if_a.o_busy, if_a.o_coin_reject}, 0);
    reset = 1'b0;
    // funding to 2000 makes every stocked item available; buy the 2000 item
    drive(3'b001, 4'b0000, 1'b0, 1'b0);
    drive(3'b001, 4'b0000, 1'b0, 1'b0);
    check("fund_balance", 0, 32'(if_a.o_balance), 2000);
    check("fund_avail", 1, 32'(if_b.o_available_item), 32'b1111);
    drive(3'b000, 4'b1000, 1'b0, 1'b0);
    check("buy3_item", 0, 32'(if_a.o_output_item), 32'b1000);
    check("buy3_balance", 0, 32'(if_a.o_balance), 0);
    // 500 + 100 then select items 0 and 2: only item 0 served
    drive(3'b010, 4'b0000, 1'b0, 1'b0);
    drive(3'b100, 4'b0000, 1'b0, 1'b0);
    drive(3'b000, 4'b0101, 1'b0, 1'b0);
    check("sel_item", 0, 32'(if_a.o_output_item), 32'b0001);
    check("sel_balance", 0, 32'(if_a.o_balance), 200);
    idle(1);
    check("sel_pulse_end", 0, 32'(if_a.o_output_item), 0);
    // 700 change: 500, 100, 100
    drive(3'b010, 4'b0000, 1'b0, 1'b0);
    drive(3'b000, 4'b0000, 1'b1, 1'b0);
    check("ret1_coin", 0, {28'd0, if_a.o_busy, if_a.o_return_coin}, 32'b1010);
    idle(1);
    check("ret2_coin", 0, {28'd0, if_a.o_busy, if_a.o_return_coin}, 32'b1100);
    idle(1);
    check("ret3_coin", 0, {28'd0, if_a.o_busy, if_a.o_return_coin}, 32'b1100);
    idle(1);
    check("ret_done", 0, {20'd0, if_a.o_busy, if_a.o_balance}, 0);
    // timeout 8 cycles after a single insert
    drive(3'b100, 4'b0000, 1'b0, 1'b0);
    for (int c = 1; c < TO; c++) begin idle(1); check("to_wait", 0, 32'(if_a.o_busy), 0); end
    idle(1);
    check("to_fire", 0, {28'd0, if_a.o_busy, if_a.o_return_coin}, 32'b1100);
    idle(1);
    check("to_done", 0, {20'd0, if_a.o_busy, if_a.o_balance}, 0);
    // second insert 5 cycles later restarts the timeout
    drive(3'b100, 4'b0000, 1'b0, 1'b0);
    idle(4);
    drive(3'b100, 4'b0000, 1'b0, 1'b0);
    for (int c = 1; c < TO; c++) begin idle(1); check("to2_wait", 0, 32'(if_a.o_busy), 0); end
    idle(1);
    check("to2_fire", 0, {17'd0, if_a.o_busy, if_a.o_return_coin, if_a.o_balance}, {17'd0, 1'b1, 3'b100, 11'd200});
    idle(2);
    check("to2_done", 0, {20'd0, if_a.o_busy, if_a.o_balance}, 0);
    // sold out on the INIT_STOCK=1 instance, then restock
    reset = 1'b1; idle(1); reset = 1'b0;
    drive(3'b001, 4'b0000, 1'b0, 1'b0);
    drive(3'b000, 4'b0001, 1'b0, 1'b0);
    check("so_first", 1, 32'(if_b.o_output_item), 32'b0001);
    check("so_avail", 1, 32'(if_b.o_available_item), 32'b0010);
    drive(3'b000, 4'b0001, 1'b0, 1'b0);
    check("so_second_b", 1, {17'd0, if_b.o_output_item, if_b.o_balance}, {17'd0, 4'b0000, 11'd600});
    check("so_second_a", 0, {17'd0, if_a.o_output_item, if_a.o_balance}, {17'd0, 4'b0001, 11'd200});
    drive(3'b000, 4'b0000, 1'b0, 1'b1);
    check("restock_avail", 1, 32'(if_b.o_available_item), 32'b0011);
    // overflow reject at 2000, coin accepted when a purchase makes room, reject in RETURN, reset mid-payout
    reset = 1'b1; idle(1); reset = 1'b0;
    drive(3'b001, 4'b0000, 1'b0, 1'b0);
    drive(3'b001, 4'b0000, 1'b0, 1'b0);
    drive(3'b100, 4'b0000, 1'b0, 1'b0);
    check("ovf_reject", 0, {20'd0, if_a.o_coin_reject, if_a.o_balance}, {20'd0, 1'b1, 11'd2000});
    idle(1);
    check("ovf_pulse_end", 0, 32'(if_a.o_coin_reject), 0);
    drive(3'b100, 4'b0010, 1'b0, 1'b0);
    check("room_accept", 0, {16'd0, if_a.o_coin_reject, if_a.o_output_item, if_a.o_balance},
          {16'd0, 1'b0, 4'b0010, 11'd1600});
    drive(3'b000, 4'b0000, 1'b1, 1'b0);
    check("pay_first", 0, 32'(if_a.o_return_coin), 32'b001);
    drive(3'b100, 4'b0000, 1'b0, 1'b0);
    check("ret_reject", 0, {16'd0, if_a.o_coin_reject, if_a.o_return_coin, if_a.o_balance},
          {16'd0, 1'b1, 3'b010, 11'd600});
    reset = 1'b1; idle(1);
    check("rst_mid_pay", 0, {17'd0, if_a.o_busy, if_a.o_return_coin, if_a.o_balance}, 0);
    idle(1); reset = 1'b0; idle(2);
    check("after_rst", 0, {17'd0, if_a.o_busy, if_a.o_return_coin, if_a.o_balance}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
